// File: rtl/tx_byte_serializer_if.sv
// Byte serializer bundle: echo and word sources in, byte stream out.
// slave = serializer side, master = FSM/ALU plus UART transmitter side.
interface tx_byte_serializer_if #(
    parameter int BYTES_P = 4
);
    logic [7:0]           echo_data_i;
    logic                 echo_valid_i;
    logic                 echo_ready_o;
    logic [8*BYTES_P-1:0] word_i;
    logic [7:0]           opcode_i;
    logic                 word_valid_i;
    logic                 word_ready_o;
    logic [7:0]           data_o;
    logic                 valid_o;
    logic                 ready_i;
    logic                 busy_o;

    modport slave (
        input  echo_data_i, echo_valid_i,
        input  word_i, opcode_i, word_valid_i,
        input  ready_i,
        output echo_ready_o, word_ready_o,
        output data_o, valid_o, busy_o
    );

    modport master (
        output echo_data_i, echo_valid_i,
        output word_i, opcode_i, word_valid_i,
        output ready_i,
        input  echo_ready_o, word_ready_o,
        input  data_o, valid_o, busy_o
    );
endinterface

// File: rtl/tx_byte_serializer.sv
// Serializes echo bytes and LSB-first result words onto a byte stream.
// Optional response header: define TX_SER_HEADER_EN.
module tx_byte_serializer #(
    parameter int BYTES_P = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    tx_byte_serializer_if.slave  ser_if
);
    localparam int         W_C   = 8 * BYTES_P;
    localparam logic [3:0] LEN_C = 4'(BYTES_P);

`ifdef TX_SER_HEADER_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WORD = 2'd1,
        HDR  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WORD = 2'd1
    } state_t;
`endif

    state_t         state_q, state_d;
    logic [W_C-1:0] shift_q, shift_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [7:0]     data_q, data_d;
    logic           valid_q, valid_d;
    logic           slot_free;
    logic           word_rdy;
    logic           echo_rdy;
`ifdef TX_SER_HEADER_EN
    // Header bytes still to send after the opcode, low byte first.
    logic [23:0]    hdr_q, hdr_d;
    logic [1:0]     hcnt_q, hcnt_d;
`endif

    assign slot_free = !valid_q || ser_if.ready_i;

    // Next-state, output-register load and ready generation.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        valid_d  = valid_q && !ser_if.ready_i;
        word_rdy = 1'b0;
        echo_rdy = 1'b0;
`ifdef TX_SER_HEADER_EN
        hdr_d    = hdr_q;
        hcnt_d   = hcnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                word_rdy = slot_free;
                echo_rdy = slot_free && !ser_if.word_valid_i;
                if (ser_if.word_valid_i && slot_free) begin
                    valid_d = 1'b1;
`ifdef TX_SER_HEADER_EN
                    // Opcode goes straight out; the rest of the
                    // header and the word follow from registers.
                    data_d  = ser_if.opcode_i;
                    hdr_d   = {8'h00, 8'(BYTES_P), 8'h00};
                    hcnt_d  = 2'd3;
                    shift_d = ser_if.word_i;
                    cnt_d   = LEN_C;
                    state_d = HDR;
`else
                    // Byte 0 is loaded on accept for N+1 latency.
                    data_d  = ser_if.word_i[7:0];
                    shift_d = ser_if.word_i >> 8;
                    cnt_d   = LEN_C - 4'd1;
                    if (LEN_C != 4'd1) begin
                        state_d = WORD;
                    end
`endif
                end else if (ser_if.echo_valid_i && echo_rdy) begin
                    data_d  = ser_if.echo_data_i;
                    valid_d = 1'b1;
                end
            end
`ifdef TX_SER_HEADER_EN
            HDR: begin
                if (slot_free) begin
                    data_d  = hdr_q[7:0];
                    hdr_d   = hdr_q >> 8;
                    hcnt_d  = hcnt_q - 2'd1;
                    valid_d = 1'b1;
                    if (hcnt_q == 2'd1) begin
                        state_d = WORD;
                    end
                end
            end
`endif
            WORD: begin
                if (slot_free) begin
                    data_d  = shift_q[7:0];
                    shift_d = shift_q >> 8;
                    cnt_d   = cnt_q - 4'd1;
                    valid_d = 1'b1;
                    if (cnt_q == 4'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output register; reset discards any partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
`ifdef TX_SER_HEADER_EN
            hdr_q   <= '0;
            hcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
`ifdef TX_SER_HEADER_EN
            hdr_q   <= hdr_d;
            hcnt_q  <= hcnt_d;
`endif
        end
    end

    assign ser_if.data_o       = data_q;
    assign ser_if.valid_o      = valid_q;
    assign ser_if.word_ready_o = word_rdy;
    assign ser_if.echo_ready_o = echo_rdy;
    assign ser_if.busy_o       = (state_q != IDLE) || valid_q;
endmodule

// File: tb/tb_tx_byte_serializer.sv
// Scoreboard bench for tx_byte_serializer.
// Expected bytes are queued at drive time and popped on each transfer.
module tb_tx_byte_serializer;
    localparam int BP = 4;
`ifdef TX_SER_HEADER_EN
    localparam int HDR_N = 4;
    localparam logic [7:0] HOLD_B = 8'h00;
`else
    localparam int HDR_N = 0;
    localparam logic [7:0] HOLD_B = 8'hBE;
`endif
    localparam int T = BP + HDR_N;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int vec_cnt = 0;
    int err_cnt = 0;
    logic [7:0] exp_q[$];
    int w;

    tx_byte_serializer_if #(.BYTES_P(BP)) sif();

    tx_byte_serializer #(.BYTES_P(BP)) dut (
        .clk    (clk),
        .rst    (rst),
        .ser_if (sif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Every transfer must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && sif.valid_o && sif.ready_i) begin
            chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                chk("byte", 32'(sif.data_o), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic push_word(input logic [8*BP-1:0] wd, input logic [7:0] op);
`ifdef TX_SER_HEADER_EN
        exp_q.push_back(op);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'(BP));
        exp_q.push_back(8'h00);
`else
        if (op == 8'hFF) exp_q.push_back(8'h00);
`endif
        for (int i = 0; i < BP; i++) exp_q.push_back(wd[8*i +: 8]);
    endtask

    task automatic send_word(input logic [8*BP-1:0] wd, input logic [7:0] op,
                             output int waited);
        int n;
        bit ok;
        push_word(wd, op);
        sif.word_i = wd;
        sif.opcode_i = op;
        sif.word_valid_i = 1'b1;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 100) begin
            @(negedge clk);
            if (sif.word_ready_o) ok = 1'b1;
            else begin
                n++;
                @(posedge clk); #1;
            end
        end
        chk("word_accept", 32'(ok), 32'd1);
        @(posedge clk); #1;
        sif.word_valid_i = 1'b0;
        waited = n;
    endtask

    task automatic send_echo(input logic [7:0] b, output int waited);
        int n;
        bit ok;
        exp_q.push_back(b);
        sif.echo_data_i = b;
        sif.echo_valid_i = 1'b1;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 100) begin
            @(negedge clk);
            if (sif.echo_ready_o) ok = 1'b1;
            else begin
                n++;
                @(posedge clk); #1;
            end
        end
        chk("echo_accept", 32'(ok), 32'd1);
        @(posedge clk); #1;
        sif.echo_valid_i = 1'b0;
        waited = n;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || sif.busy_o) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        sif.echo_data_i = 8'h00;
        sif.echo_valid_i = 1'b0;
        sif.word_i = '0;
        sif.opcode_i = 8'h00;
        sif.word_valid_i = 1'b0;
        sif.ready_i = 1'b1;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_valid", 32'(sif.valid_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(sif.valid_o), 32'd0);
        chk("rst_data", 32'(sif.data_o), 32'd0);
        chk("rst_busy", 32'(sif.busy_o), 32'd0);
        chk("rst_wrdy", 32'(sif.word_ready_o), 32'd1);
        chk("rst_erdy", 32'(sif.echo_ready_o), 32'd1);
        @(posedge clk); #1;

        // Word without stall: valid at N+1..N+T, then low.
        send_word(32'hDEADBEEF, 8'h11, w);
        for (int i = 0; i < T; i++) begin
            @(negedge clk);
            chk("t1_valid", 32'(sif.valid_o), 32'd1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("t1_idle", 32'(sif.valid_o), 32'd0);
        chk("t1_busy", 32'(sif.busy_o), 32'd0);
        @(posedge clk); #1;
        drain("t1_drain");

        // Backpressure N+2..N+4 stretches the sequence by 3.
        send_word(32'hDEADBEEF, 8'h22, w);
        @(posedge clk); #1;
        sif.ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_hold", 32'(sif.data_o), 32'(HOLD_B));
            chk("t2_hvalid", 32'(sif.valid_o), 32'd1);
            @(posedge clk); #1;
        end
        sif.ready_i = 1'b1;
        repeat (T - 2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("t2_last", 32'(sif.valid_o), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t2_end", 32'(sif.valid_o), 32'd0);
        @(posedge clk); #1;
        drain("t2_drain");

        // Echo latency: accept at N, valid at N+1.
        send_echo(8'h30, w);
        @(negedge clk);
        chk("e_lat_valid", 32'(sif.valid_o), 32'd1);
        chk("e_lat_data", 32'(sif.data_o), 32'h30);
        @(posedge clk); #1;
        drain("e_lat_drain");

        // Echo stream at one byte per cycle.
        for (int i = 0; i < 3; i++) begin
            send_echo(8'h41 + 8'(i), w);
            chk("t3_nostall", 32'(w), 32'd0);
        end
        drain("t3_drain");

        // Word wins over a simultaneous echo; echo waits.
        send_echo(8'h41, w);
        push_word(32'h04030201, 8'h33);
        exp_q.push_back(8'h42);
        sif.word_i = 32'h04030201;
        sif.opcode_i = 8'h33;
        sif.word_valid_i = 1'b1;
        sif.echo_data_i = 8'h42;
        sif.echo_valid_i = 1'b1;
        @(negedge clk);
        chk("t4_wrdy", 32'(sif.word_ready_o), 32'd1);
        chk("t4_erdy", 32'(sif.echo_ready_o), 32'd0);
        @(posedge clk); #1;
        sif.word_valid_i = 1'b0;
        w = 1;
        while (w < 100) begin
            @(negedge clk);
            if (sif.echo_ready_o) break;
            w++;
            @(posedge clk); #1;
        end
        chk("t4_stall", 32'(w), 32'(T));
        @(posedge clk); #1;
        sif.echo_valid_i = 1'b0;
        send_echo(8'h43, w);
        drain("t4_drain");

        // Async reset after two bytes of a word.
        send_word(32'hDEADBEEF, 8'h44, w);
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("t5_valid", 32'(sif.valid_o), 32'd0);
        chk("t5_busy", 32'(sif.busy_o), 32'd0);
        chk("t5_data", 32'(sif.data_o), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_wrdy", 32'(sif.word_ready_o), 32'd1);
        chk("t5_erdy", 32'(sif.echo_ready_o), 32'd1);
        @(posedge clk); #1;
        send_word(32'h00000001, 8'h55, w);
        drain("t5_drain");

        // Back-to-back words with no bubble.
        send_word(32'hA4A3A2A1, 8'h66, w);
        send_word(32'hB4B3B2B1, 8'h77, w);
        chk("t6_wait", 32'(w), 32'(T - 1));
        @(negedge clk);
        chk("t6_valid", 32'(sif.valid_o), 32'd1);
        @(posedge clk); #1;
        drain("t6_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
